// File: rtl/seq_fsm_pkg.sv
// seq_fsm_pkg -- shared types for the capture/hold sequencer.
//   state_t : 2-bit FSM state (IDLE=00, CAPTURE=01, HOLD=10; 11 is illegal)
//   CNT_W   : dwell counter width
//   TXN_W   : handshake counter width (used when SEQ_FSM_CTRL_TXN_CNT_EN is defined)
package seq_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CAPTURE = 2'b01,
        HOLD    = 2'b10
    } state_t;

    localparam int CNT_W = 8;
    localparam int TXN_W = 16;

endpackage

// File: rtl/seq_fsm_ctrl_hold_counter.sv
// hold_counter -- loadable down-counter for the post-handshake dwell.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one; never wraps below zero
//   count     : current count
//   zero      : count == 0
module hold_counter
    import seq_fsm_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && (count != '0))
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/seq_fsm_ctrl.sv
// seq_fsm_ctrl -- capture one word, present it until accepted, then dwell
// HOLD_CYCLES cycles before the next capture is allowed.
//   clk, rst   : clock, synchronous active-high reset
//   enable     : request to capture data_in (honoured only in IDLE)
//   data_in    : word captured on an IDLE cycle with enable=1
//   out_ready  : downstream accepts out_data
//   out_valid  : out_data holds a word awaiting acceptance
//   out_data   : registered captured word
//   state_o    : current FSM state
//   busy       : state_o != IDLE
//   txn_count  : saturating handshake count (only with SEQ_FSM_CTRL_TXN_CNT_EN)
//   err        : sticky illegal-state flag, cleared only by rst
// Optional feature macro: SEQ_FSM_CTRL_TXN_CNT_EN
module seq_fsm_ctrl
    import seq_fsm_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_in,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        state_o,
    output logic              busy,
`ifdef SEQ_FSM_CTRL_TXN_CNT_EN
    output logic [TXN_W-1:0]  txn_count,
`endif
    output logic              err
);

    // Counter runs HOLD_CYCLES-1 .. 0, one HOLD cycle per value.
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q;
    logic             hs;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    assign hs       = (state_q == CAPTURE) && out_valid && out_ready;
    assign cnt_load = hs;
    assign cnt_dec  = (state_q == HOLD) && !cnt_zero;

    hold_counter #(.W(CNT_W)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (HOLD_LOAD),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        out_data  <= data_in;
                        out_valid <= 1'b1;
                        state_q   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                        state_q   <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_zero)
                        state_q <= IDLE;
                end
                default: begin
                    // Unreachable encoding: recover to IDLE and remember it.
                    state_q   <= IDLE;
                    out_valid <= 1'b0;
                    err       <= 1'b1;
                end
            endcase
        end
    end

`ifdef SEQ_FSM_CTRL_TXN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            txn_count <= '0;
        else if (hs && (txn_count != {TXN_W{1'b1}}))
            txn_count <= txn_count + 1'b1;
    end
`endif

    assign state_o = state_q;
    assign busy    = (state_q != IDLE);

    // cnt_val is observed only through cnt_zero; keep it referenced.
    logic unused_cnt;
    assign unused_cnt = ^cnt_val;

endmodule

// File: tb/tb_seq_fsm_ctrl.sv
module tb_seq_fsm_ctrl;
    import seq_fsm_pkg::*;

    localparam int DW = 8;
    localparam int HC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    state_o;
    logic          busy;
    logic          err;
`ifdef SEQ_FSM_CTRL_TXN_CNT_EN
    logic [15:0]   txn_count;
`endif

    seq_fsm_ctrl #(.DATA_W(DW), .HOLD_CYCLES(HC)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .data_in   (data_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .state_o   (state_o),
        .busy      (busy),
`ifdef SEQ_FSM_CTRL_TXN_CNT_EN
        .txn_count (txn_count),
`endif
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model: a word either waits for acceptance, or a
    // dwell of m_hold cycles is running, or the block is free.
    logic [DW-1:0] m_word = '0;
    bit            m_pend = 0;
    int            m_hold = 0;
    bit            m_err  = 0;
    int            m_txn  = 0;
    bit            m_ill  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_state();
        if (m_pend)     return 2'b01;
        if (m_hold > 0) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_update();
        if (rst) begin
            m_word = '0; m_pend = 0; m_hold = 0; m_err = 0; m_txn = 0;
        end else if (m_ill) begin
            m_pend = 0; m_hold = 0; m_err = 1;
        end else if (m_pend) begin
            if (out_ready) begin
                m_pend = 0;
                m_hold = HC;
                if (m_txn < 65535) m_txn++;
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (enable) begin
            m_word = data_in;
            m_pend = 1;
        end
        m_ill = 0;
    endtask

    task automatic check_model();
        chk("state_o",   32'(state_o),   32'(m_state()));
        chk("busy",      32'(busy),      32'(m_state() != 2'b00));
        chk("out_valid", 32'(out_valid), 32'(m_pend));
        chk("out_data",  32'(out_data),  32'(m_word));
        chk("err",       32'(err),       32'(m_err));
`ifdef SEQ_FSM_CTRL_TXN_CNT_EN
        chk("txn_count", 32'(txn_count), 32'(m_txn));
`endif
    endtask

    // One clock: model advances with the DUT, outputs compared mid-cycle.
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        // Reset 2 cycles, then 3 idle cycles with everything quiet.
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_state", 32'(state_o), 32'h0);
            chk("idle_valid", 32'(out_valid), 32'h0);
            chk("idle_busy",  32'(busy), 32'h0);
        end

        // A5 with ready held high: valid next cycle, 4 HOLD cycles, IDLE.
        enable = 1'b1; data_in = 8'hA5; out_ready = 1'b1;
        step();
        chk("a5_valid", 32'(out_valid), 32'h1);
        chk("a5_data",  32'(out_data), 32'hA5);
        chk("a5_state", 32'(state_o), 32'h1);
        enable = 1'b0;
        step();
        chk("a5_hold1", 32'(state_o), 32'h2);
        chk("a5_novalid", 32'(out_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("a5_holdn", 32'(state_o), 32'h2);
        end
        step();
        chk("a5_idle", 32'(state_o), 32'h0);
        out_ready = 1'b0;

        // 3C with ready low 5 cycles, then accepted.
        enable = 1'b1; data_in = 8'h3C;
        step();
        enable = 1'b0; data_in = 8'h00;
        for (int i = 0; i < 5; i++) begin
            chk("3c_valid", 32'(out_valid), 32'h1);
            chk("3c_data",  32'(out_data), 32'h3C);
            step();
        end
        chk("3c_valid6", 32'(out_valid), 32'h1);
        chk("3c_data6",  32'(out_data), 32'h3C);
        out_ready = 1'b1;
        step();
        chk("3c_accepted", 32'(state_o), 32'h2);
        out_ready = 1'b0;
        for (int i = 0; i < HC; i++) step();
        chk("3c_back_idle", 32'(state_o), 32'h0);

        // enable stuck high with FF while 11 is in flight.
        enable = 1'b1; data_in = 8'h11;
        step();
        data_in = 8'hFF;
        step(); step();
        chk("11_keep_cap", 32'(out_data), 32'h11);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < HC - 1; i++) begin
            step();
            chk("11_keep_hold", 32'(out_data), 32'h11);
            chk("11_in_hold", 32'(state_o), 32'h2);
        end
        step();
        chk("11_idle", 32'(state_o), 32'h0);
        chk("11_idle_data", 32'(out_data), 32'h11);
        step();
        chk("ff_capture", 32'(out_data), 32'hFF);
        chk("ff_state", 32'(state_o), 32'h1);
        enable = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        // Two dwell cycles remain now; reset must abort cleanly.
        rst = 1'b1;
        step();
        chk("rst_state", 32'(state_o), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data",  32'(out_data), 32'h0);
`ifdef SEQ_FSM_CTRL_TXN_CNT_EN
        chk("rst_txn", 32'(txn_count), 32'h0);
`endif
        rst = 1'b0;
        step();

        // Illegal encoding recovers to IDLE and latches err until reset.
        force dut.state_q = state_t'(2'b11);
        #1 release dut.state_q;
        m_ill = 1;
        step();
        chk("ill_state", 32'(state_o), 32'h0);
        chk("ill_err", 32'(err), 32'h1);
        step(); step();
        chk("ill_err_sticky", 32'(err), 32'h1);
        rst = 1'b1;
        step();
        chk("ill_err_clr", 32'(err), 32'h0);
        rst = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            enable    = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 4) < 2);
            data_in   = DW'($urandom);
            rst       = ($urandom_range(0, 79) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_fsm_ctrl.md
SEQ_FSM_CTRL -- requirements
Module: seq_fsm_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, width of captured data word.
REQ-002 Parameter HOLD_CYCLES, default 4, post-handshake dwell length in cycles; legal range 1..255.
REQ-003 The block SHALL run on one clock; reset SHALL be synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  upstream request to capture data_in.
REQ-007 data_in  input  DATA_W  upstream data, sampled only when a capture occurs.
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 out_valid  output  1  out_data holds a captured word awaiting acceptance.
REQ-010 out_data  output  DATA_W  registered captured word.
REQ-011 state_o  output  2  current FSM state encoding.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 err  output  1  sticky illegal-state flag.

Function
REQ-014 States SHALL be IDLE=2'b00, CAPTURE=2'b01, HOLD=2'b10; every state SHALL be reachable from IDLE.
REQ-015 IDLE with enable=1 SHALL load data_in into out_data and move to CAPTURE on the next edge; IDLE with enable=0 SHALL stay in IDLE.
REQ-016 In CAPTURE, out_valid SHALL be 1; out_data SHALL hold stable until handshake (out_valid & out_ready).
REQ-017 On handshake, the FSM SHALL move to HOLD and load the dwell counter with HOLD_CYCLES-1.
REQ-018 In HOLD, the counter SHALL decrement each cycle; when the counter is 0 the FSM SHALL return to IDLE, giving exactly HOLD_CYCLES cycles in HOLD.
REQ-019 enable in CAPTURE or HOLD SHALL be ignored (no capture, no queueing).
REQ-020 Capture-to-valid latency SHALL be 1 cycle; earliest re-capture SHALL occur in the first IDLE cycle after HOLD.
REQ-021 State 2'b11 SHALL transition to IDLE on the next edge and set err=1; err SHALL clear only on rst.
REQ-022 All next-state and output logic SHALL be fully specified in every branch; no inferred latches; all registers SHALL be assigned under rst.
REQ-023 busy SHALL be combinationally equal to (state_o != IDLE).

Reset
REQ-024 rst=1 at a clock edge SHALL force state=IDLE, out_valid=0, out_data=0, counter=0, err=0, regardless of the current state.
REQ-025 rst asserted in CAPTURE or HOLD SHALL abort the transaction with no handshake recorded.

Configuration
REQ-026 Macro SEQ_FSM_CTRL_TXN_CNT_EN: when defined, output txn_count (16 bits) SHALL count handshakes, saturate at 16'hFFFF, and reset to 0; when undefined, the port and counter SHALL be absent and behaviour otherwise identical.

Structure
REQ-027 Package seq_fsm_pkg SHALL hold the 2-bit state typedef and the IDLE/CAPTURE/HOLD constants.
REQ-028 The dwell counter SHALL be a sub-module hold_counter (load, decrement, zero flag, 8-bit).
REQ-029 The top level SHALL contain the state register, next-state logic, data register and err flag only.

Verification
REQ-030 rst 2 cycles, then idle 3 cycles -> state_o=00, out_valid=0, out_data=0, busy=0, err=0 throughout.
REQ-031 enable=1, data_in=8'hA5, out_ready=1 -> out_valid=1 with out_data=8'hA5 next cycle; HOLD for exactly 4 cycles; IDLE after that.
REQ-032 Capture 8'h3C, out_ready=0 for 5 cycles then 1 -> out_valid and out_data=8'h3C stable for all 6 cycles; one handshake.
REQ-033 enable=1 with data_in=8'hFF throughout CAPTURE and HOLD after capturing 8'h11 -> out_data stays 8'h11; next capture of 8'hFF only after return to IDLE.
REQ-034 rst pulsed in HOLD with counter=2 -> next cycle state_o=00, out_valid=0, out_data=0; with TXN_CNT_EN txn_count=0.
REQ-035 Force state to 2'b11 -> next cycle state_o=00, err=1; err held until rst.
